// File: rtl/gshare_predictor_pkg.sv
// Shared branch-prediction definitions: default history length, the update
// record the BEU drives from its MEM-stage fields, and the weakly-not-taken
// counter reset value expressed for any counter width.
package gshare_predictor_pkg;

    localparam int GHR_SIZE = 5;

    typedef struct packed {
        logic                valid;
        logic                taken;
        logic                mispredict;
        logic [GHR_SIZE-1:0] ghr;
        logic [GHR_SIZE-1:0] shared_index;
    } bpred_update_type;

    // Weakly not-taken: the value just below the taken threshold (MSB clear).
    function automatic int pht_weak_nt(input int counter_width);
        return (1 << (counter_width - 1)) - 1;
    endfunction

    localparam int PHT_WEAK_NT = pht_weak_nt(2);

endpackage

// File: rtl/gshare_predictor_sat_counter_update.sv
// Combinational next-state for a saturating up/down counter; shared by any
// predictor that trains per-entry confidence counters.
module sat_counter_update #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] value,
    input  logic             taken,
    output logic [WIDTH-1:0] next
);

    // Step toward the outcome, pinning at the all-ones and all-zeros rails.
    always_comb begin
        next = value;
        if (taken && (value != {WIDTH{1'b1}})) begin
            next = value + WIDTH'(1);
        end else if (!taken && (value != '0)) begin
            next = value - WIDTH'(1);
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: same-cycle lookup indexed by PC xor global
// history, MEM-stage counter training and speculative-history repair on
// mispredict. Optional event counters are enabled by GSHARE_PERF_COUNTERS_EN.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int GHR_SIZE      = 5,
    parameter int COUNTER_WIDTH = 2,
    parameter int INDEX_LSB     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         fetch_pc,
    input  logic                fetch_is_branch,
    input  logic                fetch_stall,
    output logic                pred_taken,
    output logic [GHR_SIZE-1:0] pred_ghr,
    output logic [GHR_SIZE-1:0] pred_shared_index,
    input  logic                update_valid,
    input  logic                update_taken,
    input  logic                update_mispredict,
    input  logic [GHR_SIZE-1:0] update_ghr,
    input  logic [GHR_SIZE-1:0] update_shared_index
`ifdef GSHARE_PERF_COUNTERS_EN
    ,
    output logic [31:0]         perf_updates,
    output logic [31:0]         perf_mispredicts
`endif
);

    localparam int PHT_DEPTH = 1 << GHR_SIZE;
    localparam logic [COUNTER_WIDTH-1:0] WEAK_NT =
        COUNTER_WIDTH'(pht_weak_nt(COUNTER_WIDTH));

    logic [COUNTER_WIDTH-1:0] pht_q [PHT_DEPTH];
    logic [COUNTER_WIDTH-1:0] pht_d [PHT_DEPTH];
    logic [GHR_SIZE-1:0]      ghr_q;
    logic [GHR_SIZE-1:0]      ghr_d;
    logic [GHR_SIZE-1:0]      lookup_index;
    logic [COUNTER_WIDTH-1:0] trained_ctr;
    logic                     unused_pc_bits;

    // PC bits outside the index window do not take part in the lookup.
    assign unused_pc_bits = ^fetch_pc;

    // Lookup straight from registered state; a same-cycle write is not bypassed.
    always_comb begin
        lookup_index      = fetch_pc[INDEX_LSB +: GHR_SIZE] ^ ghr_q;
        pred_taken        = pht_q[lookup_index][COUNTER_WIDTH-1];
        pred_ghr          = ghr_q;
        pred_shared_index = lookup_index;
    end

    sat_counter_update #(
        .WIDTH (COUNTER_WIDTH)
    ) u_sat_counter_update (
        .value (pht_q[update_shared_index]),
        .taken (update_taken),
        .next  (trained_ctr)
    );

    // Train the entry the resolving branch looked up at fetch.
    always_comb begin
        pht_d = pht_q;
        if (update_valid) begin
            pht_d[update_shared_index] = trained_ctr;
        end
    end

    // History: mispredict repair from the carried snapshot beats the speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (update_valid && update_mispredict) begin
            ghr_d = {update_ghr[GHR_SIZE-2:0], update_taken};
        end else if (fetch_is_branch && !fetch_stall) begin
            ghr_d = {ghr_q[GHR_SIZE-2:0], pred_taken};
        end
    end

    // State registers; reset overrides any concurrent training or repair.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht_q[i] <= WEAK_NT;
            end
            ghr_q <= '0;
        end else begin
            pht_q <= pht_d;
            ghr_q <= ghr_d;
        end
    end

`ifdef GSHARE_PERF_COUNTERS_EN
    logic [31:0] perf_updates_q;
    logic [31:0] perf_updates_d;
    logic [31:0] perf_mispredicts_q;
    logic [31:0] perf_mispredicts_d;

    // Event counts wrap naturally at 2**32.
    always_comb begin
        perf_updates_d     = perf_updates_q;
        perf_mispredicts_d = perf_mispredicts_q;
        if (update_valid) begin
            perf_updates_d = perf_updates_q + 32'd1;
            if (update_mispredict) begin
                perf_mispredicts_d = perf_mispredicts_q + 32'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_updates_q     <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            perf_updates_q     <= perf_updates_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    assign perf_updates     = perf_updates_q;
    assign perf_mispredicts = perf_mispredicts_q;
`else
    // No event counters in this build.
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor (default parameters): a vector table
// checked each cycle before the clock edge, plus a hand-written training and
// repair sequence. Event-counter checks are built when GSHARE_PERF_COUNTERS_EN is set.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        fetch_is_branch;
    logic        fetch_stall;
    logic        pred_taken;
    logic [4:0]  pred_ghr;
    logic [4:0]  pred_shared_index;
    logic        update_valid;
    logic        update_taken;
    logic        update_mispredict;
    logic [4:0]  update_ghr;
    logic [4:0]  update_shared_index;
`ifdef GSHARE_PERF_COUNTERS_EN
    logic [31:0] perf_updates;
    logic [31:0] perf_mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gshare_predictor dut (
        .clk                 (clk),
        .reset               (reset),
        .fetch_pc            (fetch_pc),
        .fetch_is_branch     (fetch_is_branch),
        .fetch_stall         (fetch_stall),
        .pred_taken          (pred_taken),
        .pred_ghr            (pred_ghr),
        .pred_shared_index   (pred_shared_index),
        .update_valid        (update_valid),
        .update_taken        (update_taken),
        .update_mispredict   (update_mispredict),
        .update_ghr          (update_ghr),
        .update_shared_index (update_shared_index)
`ifdef GSHARE_PERF_COUNTERS_EN
        ,
        .perf_updates        (perf_updates),
        .perf_mispredicts    (perf_mispredicts)
`endif
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        br;
        logic        stall;
        logic        uv;
        logic        ut;
        logic        um;
        logic [4:0]  ug;
        logic [4:0]  ui;
        logic        exp_taken;
        logic [4:0]  exp_ghr;
        logic [4:0]  exp_idx;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [31:0] pc, input logic br,
                                input logic stall, input logic uv, input logic ut,
                                input logic um, input logic [4:0] ug, input logic [4:0] ui,
                                input logic et, input logic [4:0] eg, input logic [4:0] ei);
        vec_t v;
        v.rst = rst; v.pc = pc; v.br = br; v.stall = stall;
        v.uv = uv; v.ut = ut; v.um = um; v.ug = ug; v.ui = ui;
        v.exp_taken = et; v.exp_ghr = eg; v.exp_idx = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        reset = 1'b0; fetch_pc = 32'h0; fetch_is_branch = 1'b0; fetch_stall = 1'b0;
        update_valid = 1'b0; update_taken = 1'b0; update_mispredict = 1'b0;
        update_ghr = 5'd0; update_shared_index = 5'd0;
    endtask

    initial begin
        // Each row: inputs held for one cycle; expectations seen before that cycle's edge.
        vecs.push_back(mk(1, 32'h8, 0,0, 0,0,0, 5'd0, 5'd0,  0, 5'd0, 5'd4));   // 0 reset held
        vecs.push_back(mk(0, 32'h8, 0,0, 0,0,0, 5'd0, 5'd0,  0, 5'd0, 5'd4));   // 1 cycle after reset
        vecs.push_back(mk(0, 32'h8, 0,0, 1,1,0, 5'd0, 5'd4,  0, 5'd0, 5'd4));   // 2 write idx4, old 01 seen
        vecs.push_back(mk(0, 32'h8, 0,0, 1,1,0, 5'd0, 5'd4,  1, 5'd0, 5'd4));   // 3 sees 10, writes 11
        vecs.push_back(mk(0, 32'h8, 0,0, 0,0,0, 5'd0, 5'd0,  1, 5'd0, 5'd4));   // 4 idx4 = 11
        vecs.push_back(mk(0, 32'hE, 0,0, 1,1,0, 5'd0, 5'd7,  0, 5'd0, 5'd7));   // 5 idx7 01->10
        vecs.push_back(mk(0, 32'hE, 0,0, 1,1,0, 5'd0, 5'd7,  1, 5'd0, 5'd7));   // 6 10->11
        vecs.push_back(mk(0, 32'hE, 0,0, 1,1,0, 5'd0, 5'd7,  1, 5'd0, 5'd7));   // 7 sat 11
        vecs.push_back(mk(0, 32'hE, 0,0, 1,1,0, 5'd0, 5'd7,  1, 5'd0, 5'd7));   // 8 sat 11
        vecs.push_back(mk(0, 32'hE, 0,0, 1,1,0, 5'd0, 5'd7,  1, 5'd0, 5'd7));   // 9 sat 11
        vecs.push_back(mk(0, 32'hE, 0,0, 1,0,0, 5'd0, 5'd7,  1, 5'd0, 5'd7));   // 10 11->10
        vecs.push_back(mk(0, 32'hE, 0,0, 0,0,0, 5'd0, 5'd0,  1, 5'd0, 5'd7));   // 11 still taken
        vecs.push_back(mk(0, 32'hE, 0,0, 1,0,0, 5'd0, 5'd7,  1, 5'd0, 5'd7));   // 12 10->01
        vecs.push_back(mk(0, 32'hE, 0,0, 0,0,0, 5'd0, 5'd0,  0, 5'd0, 5'd7));   // 13 now not taken
        vecs.push_back(mk(0, 32'hE, 0,0, 1,0,0, 5'd0, 5'd7,  0, 5'd0, 5'd7));   // 14 01->00
        vecs.push_back(mk(0, 32'hE, 0,0, 1,0,0, 5'd0, 5'd7,  0, 5'd0, 5'd7));   // 15 sat 00
        vecs.push_back(mk(0, 32'hE, 0,0, 1,0,0, 5'd0, 5'd7,  0, 5'd0, 5'd7));   // 16
        vecs.push_back(mk(0, 32'hE, 0,0, 1,0,0, 5'd0, 5'd7,  0, 5'd0, 5'd7));   // 17
        vecs.push_back(mk(0, 32'hE, 0,0, 1,0,0, 5'd0, 5'd7,  0, 5'd0, 5'd7));   // 18
        vecs.push_back(mk(0, 32'hE, 0,0, 0,0,0, 5'd0, 5'd0,  0, 5'd0, 5'd7));   // 19
        vecs.push_back(mk(0, 32'hE, 0,0, 1,1,0, 5'd0, 5'd7,  0, 5'd0, 5'd7));   // 20 00->01
        vecs.push_back(mk(0, 32'hE, 0,0, 0,0,0, 5'd0, 5'd0,  0, 5'd0, 5'd7));   // 21 01: no wrap
        vecs.push_back(mk(0, 32'h8, 1,0, 0,0,0, 5'd0, 5'd0,  1, 5'd0, 5'd4));   // 22 shift 1 -> 00001
        vecs.push_back(mk(0, 32'hA, 1,0, 0,0,0, 5'd0, 5'd0,  1, 5'd1, 5'd4));   // 23 -> 00011
        vecs.push_back(mk(0, 32'hE, 1,0, 0,0,0, 5'd0, 5'd0,  1, 5'd3, 5'd4));   // 24 -> 00111
        vecs.push_back(mk(0, 32'h6, 1,1, 0,0,0, 5'd0, 5'd0,  1, 5'd7, 5'd4));   // 25 stalled: hold
        vecs.push_back(mk(0, 32'h6, 0,0, 0,0,0, 5'd0, 5'd0,  1, 5'd7, 5'd4));   // 26 still 00111
        vecs.push_back(mk(0, 32'h6, 1,0, 1,1,1, 5'd6, 5'd4,  1, 5'd7, 5'd4));   // 27 repair -> 01101
        vecs.push_back(mk(0, 32'h0, 0,0, 0,0,0, 5'd0, 5'd0,  0, 5'd13, 5'd13)); // 28
        vecs.push_back(mk(0, 32'h0, 0,0, 1,0,0, 5'd0, 5'd13, 0, 5'd13, 5'd13)); // 29 correct: ghr holds
        vecs.push_back(mk(0, 32'h0, 0,0, 0,0,0, 5'd0, 5'd0,  0, 5'd13, 5'd13)); // 30
        vecs.push_back(mk(0, 32'h0, 0,0, 1,0,1, 5'd21,5'd13, 0, 5'd13, 5'd13)); // 31 repair -> 01010
        vecs.push_back(mk(0, 32'h0, 0,0, 0,0,0, 5'd0, 5'd0,  0, 5'd10, 5'd10)); // 32
        vecs.push_back(mk(1, 32'h0, 1,0, 1,1,1, 5'd7, 5'd4,  0, 5'd10, 5'd10)); // 33 reset beats update
        vecs.push_back(mk(0, 32'h8, 0,0, 0,0,0, 5'd0, 5'd0,  0, 5'd0, 5'd4));   // 34 idx4 back to 01
        vecs.push_back(mk(0, 32'hE, 0,0, 0,0,0, 5'd0, 5'd0,  0, 5'd0, 5'd7));   // 35 idx7 back to 01

        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; fetch_pc = vecs[i].pc;
            fetch_is_branch = vecs[i].br; fetch_stall = vecs[i].stall;
            update_valid = vecs[i].uv; update_taken = vecs[i].ut;
            update_mispredict = vecs[i].um; update_ghr = vecs[i].ug;
            update_shared_index = vecs[i].ui;
            #1;
            check($sformatf("v%0d pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].exp_taken});
            check($sformatf("v%0d pred_ghr", i), {27'd0, pred_ghr}, {27'd0, vecs[i].exp_ghr});
            check($sformatf("v%0d pred_shared_index", i), {27'd0, pred_shared_index},
                  {27'd0, vecs[i].exp_idx});
        end

        // Hand sequence: reset, three trainings at index 2, the last a taken mispredict.
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        @(negedge clk);
        drive_idle();
        #1;
        check("seq reset ghr", {27'd0, pred_ghr}, 32'd0);
`ifdef GSHARE_PERF_COUNTERS_EN
        check("seq reset perf_updates", perf_updates, 32'd0);
        check("seq reset perf_mispredicts", perf_mispredicts, 32'd0);
`endif
        @(negedge clk);
        update_valid = 1'b1; update_taken = 1'b1; update_shared_index = 5'd2;
        @(negedge clk);
        @(negedge clk);
        update_mispredict = 1'b1; update_ghr = 5'b00011;
        @(negedge clk);
        drive_idle();
        fetch_pc = 32'hA;   // index 5 ^ ghr 00111 = 2
        #1;
        check("seq repaired ghr", {27'd0, pred_ghr}, 32'd7);
        check("seq index", {27'd0, pred_shared_index}, 32'd2);
        check("seq trained taken", {31'd0, pred_taken}, 32'd1);
`ifdef GSHARE_PERF_COUNTERS_EN
        check("seq perf_updates", perf_updates, 32'd3);
        check("seq perf_mispredicts", perf_mispredicts, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
